// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode handshakes.
// The fetch stage connects as master; memory, execute and decode sit on the slave side.
interface if_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, id_pc_plus4,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, id_pc_plus4,
        output id_ready
    );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps one fetch outstanding and
// hands {instr, pc} to decode through an IF/ID register backed by one skid entry.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rst_n,
    if_stage_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;

    logic        req_fire;
    logic        rsp_keep;
    logic        id_free;
    logic [31:0] rsp_pc;

    assign bus.imem_req_valid = rst_n && (state_q == IDLE) && !skid_valid_q && !bus.redirect_valid;
    assign bus.imem_req_addr  = {pc_q[31:2], 2'b00};

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep = (state_q == WAIT) && bus.imem_rsp_valid;
    assign id_free  = !id_valid_q || bus.id_ready;
    // In WAIT the pc has already stepped past the outstanding request.
    assign rsp_pc   = {pc_q[31:2], 2'b00} - 32'd4;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;

        if (bus.redirect_valid) begin
            pc_d         = {bus.redirect_pc[31:2], 2'b00};
            id_valid_d   = 1'b0;
            id_instr_d   = NOP_INSTR;
            skid_valid_d = 1'b0;
            if (state_q != IDLE) begin
                state_d = bus.imem_rsp_valid ? IDLE : DROP;
            end
        end else begin
            if (req_fire) begin
                pc_d    = pc_q + 32'd4;
                state_d = WAIT;
            end
            if ((state_q != IDLE) && bus.imem_rsp_valid) begin
                state_d = IDLE;
            end

            // Skid drains ahead of a fresh response so delivery order is kept.
            if (id_free) begin
                if (skid_valid_q) begin
                    id_valid_d    = 1'b1;
                    id_instr_d    = skid_instr_q;
                    id_pc_d       = skid_pc_q;
                    id_pc_plus4_d = skid_pc_q + 32'd4;
                    skid_valid_d  = rsp_keep;
                    skid_instr_d  = bus.imem_rsp_data;
                    skid_pc_d     = rsp_pc;
                end else if (rsp_keep) begin
                    id_valid_d    = 1'b1;
                    id_instr_d    = bus.imem_rsp_data;
                    id_pc_d       = rsp_pc;
                    id_pc_plus4_d = rsp_pc + 32'd4;
                end else begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end
            end else if (rsp_keep) begin
                skid_valid_d = 1'b1;
                skid_instr_d = bus.imem_rsp_data;
                skid_pc_d    = rsp_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= '0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= 32'd4;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: queue-level model of the fetch pipe checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Instruction memory: fixed words at the first two addresses, address-derived elsewhere.
    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h8000_0000) return 32'h0050_0093;
        if (addr == 32'h8000_0004) return 32'h00A0_0113;
        return {addr[23:0], 8'h13};
    endfunction

    typedef struct {
        int          cnt;
        logic [31:0] addr;
    } pend_t;

    pend_t due[$];
    int    lat = 1;

    always @(negedge clk) begin
        if (bus.imem_req_valid && bus.imem_req_ready)
            due.push_back('{cnt: lat, addr: bus.imem_req_addr});
    end

    always @(posedge clk) begin
        #1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < due.size(); i++) due[i].cnt--;
        if (due.size() > 0 && due[0].cnt <= 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_data(due[0].addr);
            void'(due.pop_front());
        end
    end

    // Model: pc, one outstanding-fetch flag with keep/discard, and a FIFO of
    // up to two delivered instructions whose head is what decode sees.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic [31:0] m_last_pc;
    bit          m_out;
    bit          m_keep;

    task automatic model_reset();
        m_q.delete();
        m_pc      = RESET_PC;
        m_req_pc  = '0;
        m_last_pc = '0;
        m_out     = 0;
        m_keep    = 0;
    endtask

    function automatic bit exp_req_valid();
        return rst_n && !m_out && (m_q.size() < 2) && !bus.redirect_valid;
    endfunction

    task automatic model_compare();
        bit v;
        v = m_q.size() > 0;
        check("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_req_valid()});
        check("req_addr", bus.imem_req_addr, {m_pc[31:2], 2'b00});
        check("id_valid", {31'b0, bus.id_valid}, {31'b0, v});
        check("id_instr", bus.id_instr, v ? m_q[0].instr : NOP_INSTR);
        check("id_pc", bus.id_pc, m_last_pc);
        check("id_pc_plus4", bus.id_pc_plus4, m_last_pc + 32'd4);
    endtask

    task automatic model_step();
        bit fire;
        fire = exp_req_valid() && bus.imem_req_ready;
        if (bus.redirect_valid) begin
            m_pc = {bus.redirect_pc[31:2], 2'b00};
            m_q.delete();
            if (m_out) begin
                if (bus.imem_rsp_valid) m_out = 0;
                else m_keep = 0;
            end
        end else begin
            if (m_q.size() > 0 && bus.id_ready) void'(m_q.pop_front());
            if (m_out && bus.imem_rsp_valid) begin
                if (m_keep) m_q.push_back('{instr: bus.imem_rsp_data, pc: m_req_pc});
                m_out = 0;
            end
            if (fire) begin
                m_out    = 1;
                m_keep   = 1;
                m_req_pc = {m_pc[31:2], 2'b00};
                m_pc     = m_pc + 32'd4;
            end
        end
        if (m_q.size() > 0) m_last_pc = m_q[0].pc;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        model_compare();
        if (rst_n) model_step();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_id_valid(input int max);
        int n = 0;
        @(negedge clk);
        while (!bus.id_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_id_valid", {31'b0, bus.id_valid}, 32'd1);
    endtask

    task automatic wait_accept(input int max);
        int n = 0;
        @(negedge clk);
        while (!(bus.imem_req_valid && bus.imem_req_ready) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_accept", {31'b0, bus.imem_req_valid && bus.imem_req_ready}, 32'd1);
    endtask

    task automatic wait_req_valid(input int max);
        int n = 0;
        @(negedge clk);
        while (!bus.imem_req_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        check("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
        check("rst_id_instr", bus.id_instr, 32'h0000_0013);
        check("rst_id_pc", bus.id_pc, 32'h0000_0000);
        check("rst_id_pc_plus4", bus.id_pc_plus4, 32'h0000_0004);
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);

        // Decode stalled from release: first word lands in IF/ID, second in skid.
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req_addr", bus.imem_req_addr, 32'h8000_0000);
        repeat (5) step();
        @(negedge clk);
        check("stall_id_pc", bus.id_pc, 32'h8000_0000);
        check("stall_id_instr", bus.id_instr, 32'h0050_0093);
        check("stall_id_pc_plus4", bus.id_pc_plus4, 32'h8000_0004);
        check("stall_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        step();
        bus.id_ready = 1'b1;
        @(negedge clk);
        step();
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        check("drain_id_pc", bus.id_pc, 32'h8000_0004);
        check("drain_id_instr", bus.id_instr, 32'h00A0_0113);
        check("drain_id_pc_plus4", bus.id_pc_plus4, 32'h8000_0008);
        check("resume_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("resume_req_addr", bus.imem_req_addr, 32'h8000_0008);

        // Memory not ready: address must hold, then one accept moves pc by 4.
        repeat (2) begin
            step();
            @(negedge clk);
            check("hold_req_addr", bus.imem_req_addr, 32'h8000_0008);
        end
        step();
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("wait_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        check("advanced_addr", bus.imem_req_addr, 32'h8000_000C);

        // Redirect while the fetch is still in flight: its response is dropped.
        lat = 3;
        wait_accept(10);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0101;
        @(negedge clk);
        check("redir_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        wait_req_valid(10);
        check("redir_req_addr", bus.imem_req_addr, 32'h8000_0100);
        wait_id_valid(12);
        check("redir_id_pc", bus.id_pc, 32'h8000_0100);
        check("redir_id_pc_plus4", bus.id_pc_plus4, 32'h8000_0104);
        check("redir_id_instr", bus.id_instr, 32'h0001_0013);

        // Redirect coinciding with the response: back to IDLE, target fetched next.
        lat = 1;
        wait_accept(10);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0203;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_rsp_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("redir_rsp_req_addr", bus.imem_req_addr, 32'h8000_0200);
        check("redir_rsp_id_valid", {31'b0, bus.id_valid}, 32'd0);

        // Asynchronous reset mid-WAIT with a valid instruction held.
        step();
        bus.id_ready = 1'b0;
        lat = 4;
        wait_id_valid(20);
        step();
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        #1;
        check("async_id_valid", {31'b0, bus.id_valid}, 32'd0);
        check("async_id_instr", bus.id_instr, 32'h0000_0013);
        check("async_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("async_id_pc", bus.id_pc, 32'h0000_0000);
        step();
        rst_n = 1'b1;
        step();
        step();
        @(negedge clk);
        check("late_rsp_id_valid", {31'b0, bus.id_valid}, 32'd0);
        check("late_rsp_req_addr", bus.imem_req_addr, 32'h8000_0000);
        step();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.id_ready = 1'b1;
        @(negedge clk);
        check("post_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("post_rst_req_addr", bus.imem_req_addr, 32'h8000_0000);
        wait_id_valid(10);
        check("post_rst_id_pc", bus.id_pc, 32'h8000_0000);
        check("post_rst_id_instr", bus.id_instr, 32'h0050_0093);

        repeat (6) step();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
